fib_bcd_converter: RTL
======================

Name: fib_bcd_converter

Overview:
- Downstream of the Fibonacci generator: consumes its 16-bit result and converts it to packed BCD for display.
- Captures the binary value on a rising edge of the generator's done flag.
- Sequential double-dabble (shift-add-3) conversion, one shift per clock.
- Presents 5 BCD digits, a significant-digit count and a one-cycle valid pulse to the display stage.

Parameters:
- WIDTH, 16, binary input width (matches generator numberOut).
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1.
- SCAN_DIV, 50000, clock cycles per digit in the scan driver (used only with SEG_SCAN_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  conversion request, driven by generator done; level may stay high.
- bin_in  input  WIDTH  binary value, driven by generator numberOut; sampled on accepted start.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when bcd_out and digits_used update.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 in [3:0]; holds the last result.
- digits_used  output  3  count of significant digits, 1..DIGITS (value 0 reports 1).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy=0, valid=0, bcd_out=0, digits_used=1.
  - Shift registers, iteration counter and start_q cleared.
- Edge detect:
  - start_q is start registered each cycle.
  - start_rise = start & ~start_q.
  - A start held high does not retrigger.
- States: IDLE, CONVERT.
- IDLE:
  - On start_rise, load shift register with bin_in, clear BCD scratch, count=0, set busy=1, go to CONVERT.
  - Otherwise stay in IDLE.
- CONVERT, one iteration per cycle:
  - Each scratch nibble >= 5 gets +3 (4-bit add, no carry out of the nibble).
  - Then shift {scratch, shift_reg} left by 1.
  - count increments.
- Completion on the cycle count == WIDTH-1:
  - Registered outputs take the final shifted scratch.
  - valid=1 for exactly that following cycle.
  - busy=0; state goes to IDLE.
- Latency: start_rise sampled at edge N; busy high from N+1; bcd_out, digits_used and valid update at edge N+WIDTH+1 (N+17 at default).
- digits_used = index of the highest nonzero digit + 1; 1 if all digits are zero. Computed from the final scratch in the same cycle.
- start_rise while busy: ignored and lost; no queueing.
- start_rise on the same cycle the conversion completes (state still CONVERT): ignored.
- start_rise on the first IDLE cycle after completion: accepted.
- bin_in changes during CONVERT: no effect; only the value latched at acceptance is converted.
- Reset mid-conversion: conversion aborted; all outputs return to reset values; no valid pulse.
- Maximum input 65535 must yield 6,5,5,3,5; no nibble ever exceeds 9 in bcd_out.

Optional Feature:
- Macro SEG_SCAN_EN.
- Defined:
  - Adds ports seg (output, 7, active-low segments a..g in [0]..[6]) and an (output, DIGITS, active-low digit enables).
  - A prescaler counts to SCAN_DIV-1, then advances a digit index 0..DIGITS-1, wrapping to 0.
  - Exactly one an bit is low at a time.
  - seg shows the hex-to-7seg pattern of the selected bcd_out digit.
  - Digits with index >= digits_used are blanked (seg=7'h7F, their an still driven) for leading-zero suppression.
  - Reset: index=0, prescaler=0, seg=7'h7F, an all ones.
- Undefined: seg and an ports, prescaler and decoder are absent; core behaviour is identical.

Test Plan:
- reset low 3 cycles, then high; bin_in=0, start rise -> busy cycles 1..16, valid at cycle 17, bcd_out=20'h00000, digits_used=1.
- bin_in=16'd65535, start rise -> after 17 cycles bcd_out=20'h65535, digits_used=5, single valid pulse.
- bin_in=16'd46368 (F24), start held high 40 cycles -> exactly one valid pulse, bcd_out=20'h46368; bin_in=16'd89 then start low/high -> bcd_out=20'h00089, digits_used=2.
- Conversion of 28657 running; new start rise with bin_in=5 at cycle 6 -> ignored, result 20'h28657; start rise after busy falls -> 20'h00005.
- reset asserted at cycle 8 of a conversion of 1000 -> busy=0, bcd_out=0 immediately, no valid pulse; post-reset conversion of 1000 -> 20'h01000, digits_used=4.
- SEG_SCAN_EN, SCAN_DIV=4, bcd_out=20'h00089 -> an cycles 11110, 11101, ... every 4 clocks; digits 0,1 show 9,8 (seg 7'h10, 7'h00); digits 2-4 seg=7'h7F.

Source files
------------

// File: rtl/fib_bcd_if.sv
// Handshake bundle between the Fibonacci generator side and the BCD converter:
// start/value request in, BCD result with digit count and valid pulse out.
interface fib_bcd_if #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
);
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  valid;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [2:0]            digits_used;

   modport master (
      output start, bin_in,
      input  busy, valid, bcd_out, digits_used
   );

   modport slave (
      input  start, bin_in,
      output busy, valid, bcd_out, digits_used
   );
endinterface

// File: rtl/fib_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Optional multiplexed 7-segment scan driver enabled by macro SEG_SCAN_EN.
module fib_bcd_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
`ifdef SEG_SCAN_EN
   ,
   parameter int SCAN_DIV = 50000
`endif
) (
   input  logic          clk,
   input  logic          reset,
   fib_bcd_if.slave      bus
`ifdef SEG_SCAN_EN
   ,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
`endif
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t              state_q;
   logic                start_q;
   logic [WIDTH-1:0]    shift_q;
   logic [4*DIGITS-1:0] scratch_q;
   logic [CNT_W-1:0]    count_q;
   logic                busy_q;
   logic                valid_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic [2:0]          used_q;

   logic                start_rise;
   logic [4*DIGITS-1:0] adj;
   logic [4*DIGITS-1:0] scratch_d;
   logic [WIDTH-1:0]    shift_d;
   logic [CNT_W-1:0]    count_d;
   logic [2:0]          used_d;

   assign start_rise = bus.start & ~start_q;

   // Add-3 correction keeps each nibble a legal BCD digit after the next shift.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                 scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
      end
   endgenerate

   assign scratch_d = {adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
   assign shift_d   = {shift_q[WIDTH-2:0], 1'b0};
   assign count_d   = count_q + 1'b1;

   always_comb begin
      used_d = 3'd1;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_d[i*4 +: 4] != 4'd0) used_d = 3'(i + 1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         shift_q   <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         bcd_q     <= '0;
         used_q    <= 3'd1;
      end else begin
         start_q <= bus.start;
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_rise) begin
                  shift_q   <= bus.bin_in;
                  scratch_q <= '0;
                  count_q   <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= CONVERT;
               end
            end
            CONVERT: begin
               scratch_q <= scratch_d;
               shift_q   <= shift_d;
               count_q   <= count_d;
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  bcd_q   <= scratch_d;
                  used_q  <= used_d;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.bcd_out     = bcd_q;
   assign bus.digits_used = used_q;

`ifdef SEG_SCAN_EN
   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PRE_W-1:0] presc_q;
   logic [IDX_W-1:0] idx_q;
   logic [3:0]       digit_sel;
   logic [6:0]       seg_d;

   assign digit_sel = bcd_q[int'(idx_q)*4 +: 4];

   // Active-low segments, a in bit 0; digits at or above digits_used are blanked.
   always_comb begin
      case (digit_sel)
         4'h0: seg_d = 7'h40;
         4'h1: seg_d = 7'h79;
         4'h2: seg_d = 7'h24;
         4'h3: seg_d = 7'h30;
         4'h4: seg_d = 7'h19;
         4'h5: seg_d = 7'h12;
         4'h6: seg_d = 7'h02;
         4'h7: seg_d = 7'h78;
         4'h8: seg_d = 7'h00;
         4'h9: seg_d = 7'h10;
         4'hA: seg_d = 7'h08;
         4'hB: seg_d = 7'h03;
         4'hC: seg_d = 7'h46;
         4'hD: seg_d = 7'h21;
         4'hE: seg_d = 7'h06;
         default: seg_d = 7'h0E;
      endcase
      if (int'(idx_q) >= int'(used_q)) seg_d = 7'h7F;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         idx_q   <= '0;
         seg     <= 7'h7F;
         an      <= '1;
      end else begin
         if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
         seg <= seg_d;
         an  <= ~(DIGITS'(1) << idx_q);
      end
   end
`endif
endmodule
